// File: rtl/exp_ro_frame_sched.sv
// Frame-level scheduler between the exposure sequencer and the readout engine.
// Runs arm/expose/handoff/readout per frame for N-shot or continuous acquisitions.
module exp_ro_frame_sched #(
  parameter int FRAME_W    = 16,
  parameter int TMO_W      = 32,
  parameter int ABORT_HOLD = 4
) (
  input  logic               CLKM,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [FRAME_W-1:0] num_frames,
  input  logic [TMO_W-1:0]   timeout_lim,
  input  logic               cfg_pending,
  input  logic               exp_trigger,
  input  logic               ro_ready,
  input  logic               ro_done,
  output logic               exp_rst,
  output logic               re_busy,
  output logic               ro_start,
  output logic               cfg_load,
  output logic               frame_done,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               busy,
  output logic               err_timeout
);

  localparam int HOLD_W = (ABORT_HOLD > 1) ? $clog2(ABORT_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ABORT_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_EXPOSE,
    S_HANDOFF,
    S_READOUT,
    S_NEXT,
    S_ABORT
  } state_t;

  state_t             state, state_nx;
  logic [TMO_W-1:0]   wd, wd_nx;
  logic [HOLD_W-1:0]  hold_cnt, hold_nx;
  logic               first, first_nx;
  logic               stop_req, stop_req_nx;
  logic [FRAME_W-1:0] cnt_nx;
  logic               err_nx;
  logic               ro_start_nx;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_nx    = state;
    wd_nx       = wd;
    hold_nx     = hold_cnt;
    first_nx    = first;
    stop_req_nx = stop_req;
    cnt_nx      = frame_cnt;
    err_nx      = err_timeout;
    ro_start_nx = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start && (continuous || (num_frames != '0))) begin
          state_nx    = S_ARM;
          cnt_nx      = '0;
          err_nx      = 1'b0;
          first_nx    = 1'b1;
          stop_req_nx = 1'b0;
        end
      end
      S_ARM: begin
        state_nx = S_EXPOSE;
        wd_nx    = '0;
        first_nx = 1'b0;
        if (stop) stop_req_nx = 1'b1;
      end
      S_EXPOSE: begin
        wd_nx = wd + TMO_W'(1);
        if (exp_trigger) begin
          state_nx = S_HANDOFF;
          // A stop coinciding with the trigger must not be lost; it ends the run at NEXT.
          if (stop) stop_req_nx = 1'b1;
        end else if ((timeout_lim != '0) && (wd == timeout_lim - TMO_W'(1))) begin
          state_nx = S_ABORT;
          err_nx   = 1'b1;
        end else if (stop || stop_req) begin
          state_nx = S_ABORT;
        end
      end
      S_HANDOFF: begin
        if (stop) stop_req_nx = 1'b1;
        if (!exp_trigger && ro_ready) begin
          state_nx    = S_READOUT;
          ro_start_nx = 1'b1;
        end
      end
      S_READOUT: begin
        if (stop) stop_req_nx = 1'b1;
        if (ro_done) state_nx = S_NEXT;
      end
      S_NEXT: begin
        // frame_cnt already holds the incremented count while in NEXT.
        if (stop_req || stop) state_nx = S_IDLE;
        else if (!continuous && (frame_cnt == num_frames)) state_nx = S_IDLE;
        else state_nx = S_ARM;
      end
      S_ABORT: begin
        if (hold_cnt == HOLD_LAST) state_nx = S_IDLE;
        else hold_nx = hold_cnt + HOLD_W'(1);
      end
      default: state_nx = S_IDLE;
    endcase

    if ((state == S_READOUT) && (state_nx == S_NEXT)) cnt_nx = frame_cnt + FRAME_W'(1);
    if ((state != S_ABORT) && (state_nx == S_ABORT)) hold_nx = '0;
  end

  // Outputs are registered from the next state so each one is valid for the whole state.
  always_ff @(posedge CLKM) begin
    if (rst) begin
      state       <= S_IDLE;
      wd          <= '0;
      hold_cnt    <= '0;
      first       <= 1'b0;
      stop_req    <= 1'b0;
      frame_cnt   <= '0;
      err_timeout <= 1'b0;
      exp_rst     <= 1'b1;
      re_busy     <= 1'b1;
      ro_start    <= 1'b0;
      cfg_load    <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state       <= state_nx;
      wd          <= wd_nx;
      hold_cnt    <= hold_nx;
      first       <= first_nx;
      stop_req    <= stop_req_nx;
      frame_cnt   <= cnt_nx;
      err_timeout <= err_nx;
      exp_rst     <= (state_nx == S_IDLE) || (state_nx == S_ABORT);
      re_busy     <= !((state_nx == S_ARM) || (state_nx == S_EXPOSE));
      ro_start    <= ro_start_nx;
      cfg_load    <= (state_nx == S_ARM) && (first_nx || cfg_pending);
      frame_done  <= (state_nx == S_NEXT);
      busy        <= (state_nx != S_IDLE);
    end
  end

endmodule
